// File: rtl/pc_stack_seq.sv
`default_nettype none
// ============================================================================
//  Module   : pc_stack_seq
//  Purpose  : Program-counter sequencer for the game CPU core. Provides
//             increment, relative branch, absolute jump, and call/return
//             through a hardware return-address stack with status flags.
//  Ports    : clk, reset        - clock / synchronous active-high reset
//             pc_en             - advance PC by one
//             branch_en/off     - PC += sign-extended branch_off
//             jump_en/addr      - PC <= jump_addr (also the call target)
//             call_en           - push PC+1, then PC <= jump_addr
//             ret_en            - pop top of stack into PC
//             pc_out            - current fetch address
//             stack_count       - number of valid stack entries
//             stack_full/empty  - stack occupancy status
//             stack_err         - sticky overflow/underflow flag
//  Revision : 1.0 - initial release
// ============================================================================
module pc_stack_seq #(
   parameter int ADDR_W      = 14,
   parameter int OFF_W       = 10,
   parameter int RESET_VEC   = 9,
   parameter int STACK_DEPTH = 8,
   parameter int PTR_W       = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pc_en,
   input  logic              branch_en,
   input  logic [OFF_W-1:0]  branch_off,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic              call_en,
   input  logic              ret_en,
   output logic [ADDR_W-1:0] pc_out,
   output logic [PTR_W:0]    stack_count,
   output logic              stack_full,
   output logic              stack_empty,
   output logic              stack_err
);

   localparam logic [ADDR_W-1:0] c_RESET_VEC = ADDR_W'(RESET_VEC);
   localparam logic [PTR_W:0]    c_DEPTH     = (PTR_W+1)'(STACK_DEPTH);

   // The PC is held XORed with the reset vector, so an all-zero register
   // (the power-up state of the flops) already decodes as RESET_VEC.
   logic [ADDR_W-1:0] r_pc_enc;
   logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
   logic [PTR_W:0]    r_count;
   logic              r_err;

   logic [ADDR_W-1:0] w_pc;
   logic [ADDR_W-1:0] w_pc_inc;
   logic [ADDR_W-1:0] w_off_ext;
   logic [ADDR_W-1:0] w_top;
   logic [PTR_W-1:0]  w_top_idx;
   logic [PTR_W-1:0]  w_push_idx;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic [ADDR_W-1:0] w_pc_next;
   logic [PTR_W:0]    w_count_next;
   logic              w_err_next;

   assign w_pc       = r_pc_enc ^ c_RESET_VEC;
   assign w_pc_inc   = w_pc + ADDR_W'(1);
   assign w_off_ext  = ADDR_W'($signed(branch_off));
   assign w_full     = (r_count == c_DEPTH);
   assign w_empty    = (r_count == '0);
   // Index arithmetic wraps inside PTR_W bits; the top index is only
   // consumed when the stack is non-empty and the push index only when
   // the stack is not full, so the wrap is never observed.
   assign w_top_idx  = r_count[PTR_W-1:0] - PTR_W'(1);
   assign w_push_idx = r_count[PTR_W-1:0];
   assign w_top      = r_stack[w_top_idx];

   // Single prioritised action per cycle: return, call, branch, jump, inc.
   always_comb begin
      w_pc_next    = w_pc;
      w_count_next = r_count;
      w_err_next   = r_err;
      w_push       = 1'b0;
      if (ret_en) begin
         if (w_empty) begin
            w_err_next = 1'b1;
         end else begin
            w_pc_next    = w_top;
            w_count_next = r_count - (PTR_W+1)'(1);
         end
      end else if (call_en) begin
         if (w_full) begin
            w_err_next = 1'b1;
         end else begin
            w_push       = 1'b1;
            w_pc_next    = jump_addr;
            w_count_next = r_count + (PTR_W+1)'(1);
         end
      end else if (branch_en) begin
         w_pc_next = w_pc + w_off_ext;
      end else if (jump_en) begin
         w_pc_next = jump_addr;
      end else if (pc_en) begin
         w_pc_next = w_pc_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc_enc <= '0;
         r_count  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_pc_enc <= w_pc_next ^ c_RESET_VEC;
         r_count  <= w_count_next;
         r_err    <= w_err_next;
      end
   end

   // Stack storage carries no reset so it can map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (w_push && !reset) begin
         r_stack[w_push_idx] <= w_pc_inc;
      end
   end

   assign pc_out      = w_pc;
   assign stack_count = r_count;
   assign stack_full  = w_full;
   assign stack_empty = w_empty;
   assign stack_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_stack_seq
//  Purpose  : Self-checking bench for pc_stack_seq: a directed vector table,
//             hand-written stack corner sequences and a randomised section
//             checked against a behavioural model through a result queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_stack_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_en;
   logic        branch_en;
   logic [9:0]  branch_off;
   logic        jump_en;
   logic [13:0] jump_addr;
   logic        call_en;
   logic        ret_en;
   logic [13:0] pc_out;
   logic [3:0]  stack_count;
   logic        stack_full;
   logic        stack_empty;
   logic        stack_err;

   pc_stack_seq dut (
      .clk         (clk),
      .reset       (reset),
      .pc_en       (pc_en),
      .branch_en   (branch_en),
      .branch_off  (branch_off),
      .jump_en     (jump_en),
      .jump_addr   (jump_addr),
      .call_en     (call_en),
      .ret_en      (ret_en),
      .pc_out      (pc_out),
      .stack_count (stack_count),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .stack_err   (stack_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        pe;
      logic        be;
      logic [9:0]  off;
      logic        je;
      logic [13:0] addr;
      logic        ce;
      logic        re;
      logic [13:0] e_pc;
      logic [3:0]  e_cnt;
      logic        e_err;
   } vec_t;

   typedef struct {
      logic [13:0] pc;
      logic [3:0]  cnt;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   vec_t tbl[$];
   int   total = 0;
   int   bad   = 0;

   function automatic vec_t mk(input logic rst, input logic pe, input logic be,
                               input logic [9:0] off, input logic je,
                               input logic [13:0] addr, input logic ce,
                               input logic re, input logic [13:0] e_pc,
                               input logic [3:0] e_cnt, input logic e_err);
      vec_t v;
      v.rst = rst; v.pe = pe; v.be = be; v.off = off; v.je = je;
      v.addr = addr; v.ce = ce; v.re = re;
      v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_err = e_err;
      return v;
   endfunction

   task automatic check1(input string name, input logic [13:0] act, input logic [13:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, clock, then compare.
   task automatic step(input vec_t v);
      exp_t e;
      exp_t got;
      reset      = v.rst;
      pc_en      = v.pe;
      branch_en  = v.be;
      branch_off = v.off;
      jump_en    = v.je;
      jump_addr  = v.addr;
      call_en    = v.ce;
      ret_en     = v.re;
      e.pc  = v.e_pc;
      e.cnt = v.e_cnt;
      e.err = v.e_err;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard: queue empty, expected one entry");
      end else begin
         got = sb_q.pop_front();
         check1("pc_out", pc_out, got.pc);
         check1("stack_count", 14'(stack_count), 14'(got.cnt));
         check1("stack_full", 14'(stack_full), 14'(got.cnt == 4'd8));
         check1("stack_empty", 14'(stack_empty), 14'(got.cnt == 4'd0));
         check1("stack_err", 14'(stack_err), 14'(got.err));
      end
   endtask

   // Behavioural reference for the randomised section.
   logic [13:0] m_pc;
   logic [3:0]  m_cnt;
   logic        m_err;
   logic [13:0] m_stk [8];

   initial begin
      vec_t v;
      reset = 1'b1; pc_en = 1'b0; branch_en = 1'b0; branch_off = '0;
      jump_en = 1'b0; jump_addr = '0; call_en = 1'b0; ret_en = 1'b0;
      @(posedge clk);
      #1;

      //            rst pe be off     je addr     ce re  pc       cnt  err
      tbl.push_back(mk(1, 0, 0, 10'h000, 0, 14'h0000, 0, 0, 14'd9,    4'd0, 0));
      tbl.push_back(mk(0, 1, 0, 10'h000, 0, 14'h0000, 0, 0, 14'd10,   4'd0, 0));
      tbl.push_back(mk(0, 1, 0, 10'h000, 0, 14'h0000, 0, 0, 14'd11,   4'd0, 0));
      tbl.push_back(mk(0, 1, 0, 10'h000, 0, 14'h0000, 0, 0, 14'd12,   4'd0, 0));
      tbl.push_back(mk(0, 0, 1, 10'h3FC, 0, 14'h0000, 0, 0, 14'd8,    4'd0, 0));
      tbl.push_back(mk(0, 0, 1, 10'h004, 1, 14'h0123, 0, 0, 14'd12,   4'd0, 0));
      tbl.push_back(mk(0, 0, 0, 10'h000, 1, 14'd20,   0, 0, 14'd20,   4'd0, 0));
      tbl.push_back(mk(0, 0, 0, 10'h000, 0, 14'd100,  1, 0, 14'd100,  4'd1, 0));
      tbl.push_back(mk(0, 0, 0, 10'h000, 0, 14'd200,  1, 0, 14'd200,  4'd2, 0));
      tbl.push_back(mk(0, 0, 0, 10'h000, 0, 14'h0000, 0, 1, 14'd101,  4'd1, 0));
      tbl.push_back(mk(0, 0, 0, 10'h000, 0, 14'h0000, 0, 1, 14'd21,   4'd0, 0));
      tbl.push_back(mk(0, 0, 0, 10'h000, 1, 14'd20,   0, 0, 14'd20,   4'd0, 0));
      tbl.push_back(mk(0, 0, 0, 10'h000, 0, 14'd100,  1, 0, 14'd100,  4'd1, 0));
      tbl.push_back(mk(0, 0, 0, 10'h000, 0, 14'd500,  1, 1, 14'd21,   4'd0, 0));
      tbl.push_back(mk(0, 0, 0, 10'h000, 1, 14'h3FFF, 0, 0, 14'h3FFF, 4'd0, 0));
      tbl.push_back(mk(0, 1, 0, 10'h000, 0, 14'h0000, 0, 0, 14'h0000, 4'd0, 0));
      tbl.push_back(mk(0, 1, 0, 10'h000, 1, 14'd5,    0, 0, 14'd5,    4'd0, 0));
      tbl.push_back(mk(0, 0, 1, 10'h3FF, 0, 14'h0000, 0, 0, 14'd4,    4'd0, 0));
      tbl.push_back(mk(0, 0, 1, 10'h3F8, 0, 14'h0000, 0, 0, 14'h3FFC, 4'd0, 0));
      tbl.push_back(mk(0, 0, 1, 10'h1FF, 0, 14'h0000, 0, 0, 14'h01FB, 4'd0, 0));
      tbl.push_back(mk(0, 0, 0, 10'h000, 0, 14'h0555, 0, 0, 14'h01FB, 4'd0, 0));

      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // Fill the stack with eight nested calls.
      for (int i = 0; i < 8; i++)
         step(mk(0, 0, 0, 10'h000, 0, 14'h1000 + 14'(i), 1, 0,
                 14'h1000 + 14'(i), 4'(i + 1), 0));
      // Ninth call overflows: PC holds, no push, error latches.
      step(mk(0, 1, 0, 10'h000, 0, 14'h2000, 1, 0, 14'h1007, 4'd8, 1));
      // Unwind in LIFO order; the first pushed entry was 0x01FB + 1.
      for (int k = 0; k < 8; k++)
         step(mk(0, 0, 0, 10'h000, 0, 14'h0000, 0, 1,
                 (k == 7) ? 14'h01FC : 14'h1007 - 14'(k), 4'(7 - k), 1));
      // Underflow with a lower-priority enable present: PC holds.
      step(mk(0, 1, 0, 10'h000, 0, 14'h0000, 0, 1, 14'h01FC, 4'd0, 1));
      // Reset overrides concurrent enables and clears the sticky flag.
      step(mk(1, 1, 0, 10'h000, 0, 14'h0777, 1, 0, 14'd9,    4'd0, 0));
      step(mk(0, 0, 0, 10'h000, 0, 14'h0000, 0, 1, 14'd9,    4'd0, 1));
      step(mk(0, 1, 0, 10'h000, 0, 14'h0000, 0, 0, 14'd10,   4'd0, 1));
      step(mk(0, 0, 0, 10'h000, 0, 14'h0040, 1, 0, 14'h0040, 4'd1, 1));
      step(mk(1, 0, 0, 10'h000, 0, 14'h0080, 1, 0, 14'd9,    4'd0, 0));

      // Randomised traffic checked against the model.
      m_pc = 14'd9; m_cnt = 4'd0; m_err = 1'b0;
      for (int n = 0; n < 400; n++) begin
         v.rst  = ($urandom_range(0, 59) == 0);
         v.pe   = ($urandom_range(0, 9) < 4);
         v.be   = ($urandom_range(0, 9) < 2);
         v.off  = 10'($urandom);
         v.je   = ($urandom_range(0, 9) < 2);
         v.addr = 14'($urandom);
         v.ce   = ($urandom_range(0, 9) < 4);
         v.re   = ($urandom_range(0, 9) < 3);
         if (v.rst) begin
            m_pc = 14'd9; m_cnt = 4'd0; m_err = 1'b0;
         end else if (v.re) begin
            if (m_cnt == 0) m_err = 1'b1;
            else begin
               m_cnt = m_cnt - 4'd1;
               m_pc  = m_stk[m_cnt[2:0]];
            end
         end else if (v.ce) begin
            if (m_cnt == 4'd8) m_err = 1'b1;
            else begin
               m_stk[m_cnt[2:0]] = m_pc + 14'd1;
               m_cnt = m_cnt + 4'd1;
               m_pc  = v.addr;
            end
         end else if (v.be) begin
            m_pc = m_pc + {{4{v.off[9]}}, v.off};
         end else if (v.je) begin
            m_pc = v.addr;
         end else if (v.pe) begin
            m_pc = m_pc + 14'd1;
         end
         v.e_pc = m_pc; v.e_cnt = m_cnt; v.e_err = m_err;
         step(v);
      end

      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
